// File: rtl/muldiv_if.sv
// muldiv_if: request/response handshake bundle for muldiv_unit
// Signals: in_valid/in_ready/funct3/a/b (request), out_valid/out_ready/t (response), busy (status).
// master drives requests and consumes results; slave is the execute unit.
interface muldiv_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] t;
    logic            busy;
    modport master (output in_valid, funct3, a, b, out_ready, input in_ready, out_valid, t, busy);
    modport slave (input in_valid, funct3, a, b, out_ready, output in_ready, out_valid, t, busy);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 RV M-extension multiply/divide execute unit
// Ports: clk, rst (async, active-high), io (muldiv_if.slave: request a/b/funct3 with
// in_valid/in_ready, result t with out_valid/out_ready, busy while an op is held).
// Macro MULDIV_FAST_MUL_EN: multiplies complete in one cycle; divides stay iterative.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input logic     clk,
    input logic     rst,
    muldiv_if.slave io
);
    localparam int CW = $clog2(XLEN);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   t_q, t_d;
    logic              sa, sb, div0, ovf;
    logic [XLEN-1:0]   ma, mb, spec_t, qr, rr, fix_res;
    logic [2*XLEN-1:0] pr;
    // One radix-2 step. Multiply: acc = {partial high, remaining multiplier}, shift-add of d.
    // Divide: acc = {remainder, dividend/quotient}, restoring subtract of d.
    function automatic logic [2*XLEN-1:0] step(input logic [2*XLEN-1:0] acc, input logic [XLEN-1:0] d, input logic dv);
        logic [XLEN:0]   ms, sh;
        logic            ge;
        logic [XLEN-1:0] r;
        ms = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, acc[0] ? d : {XLEN{1'b0}}};
        sh = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        ge = sh >= {1'b0, d};
        r = sh[XLEN-1:0] - (ge ? d : {XLEN{1'b0}});
        return dv ? {r, acc[XLEN-2:0], ge} : {ms, acc[XLEN-1:1]};
    endfunction
    // MULH/MULHSU treat a as signed, MULH treats b as signed; DIV/REM both signed.
    assign sa = (io.funct3[2] ? ~io.funct3[0] : io.funct3[1] ^ io.funct3[0]) & io.a[XLEN-1];
    assign sb = (io.funct3[2] ? ~io.funct3[0] : ~io.funct3[1] & io.funct3[0]) & io.b[XLEN-1];
    assign ma = sa ? -io.a : io.a;
    assign mb = sb ? -io.b : io.b;
    assign div0 = ~|io.b;
    assign ovf = ~io.funct3[0] & (io.a == {1'b1, {(XLEN-1){1'b0}}}) & (&io.b);
    assign spec_t = div0 ? (io.funct3[1] ? io.a : {XLEN{1'b1}}) : (io.funct3[1] ? {XLEN{1'b0}} : io.a);
    assign pr = neg_q ? -acc_q : acc_q;
    assign qr = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rr = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    assign fix_res = op_q[2] ? (op_q[1] ? rr : qr) : (op_q[1:0] == 2'b00 ? pr[XLEN-1:0] : pr[2*XLEN-1:XLEN]);
`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fa, fb, fp;
    assign fa = {{XLEN{sa}}, io.a};
    assign fb = {{XLEN{sb}}, io.b};
    assign fp = fa * fb;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q <= '0;
            cnt_q <= '0;
            acc_q <= '0;
            opb_q <= '0;
            neg_q <= 1'b0;
            t_q <= '0;
        end else begin
            state_q <= state_d;
            op_q <= op_d;
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            opb_q <= opb_d;
            neg_q <= neg_d;
            t_q <= t_d;
        end
    end
    // The first iteration is performed on the accept edge, so CALC needs XLEN-1 more.
    always_comb begin
        state_d = state_q;
        op_d = op_q;
        cnt_d = cnt_q;
        acc_d = acc_q;
        opb_d = opb_q;
        neg_d = neg_q;
        t_d = t_q;
        case (state_q)
            IDLE: if (io.in_valid) begin
                op_d = io.funct3;
                neg_d = (io.funct3[2] & io.funct3[1]) ? sa : sa ^ sb;
                cnt_d = CW'(XLEN-1);
                opb_d = mb;
                acc_d = step({{XLEN{1'b0}}, ma}, mb, io.funct3[2]);
                state_d = CALC;
                if (io.funct3[2] && (div0 || ovf)) begin
                    t_d = spec_t;
                    state_d = DONE;
                end
`ifdef MULDIV_FAST_MUL_EN
                if (!io.funct3[2]) begin
                    t_d = io.funct3[1:0] == 2'b00 ? fp[XLEN-1:0] : fp[2*XLEN-1:XLEN];
                    state_d = DONE;
                end
`endif
            end
            CALC: begin
                acc_d = step(acc_q, opb_q, op_q[2]);
                cnt_d = cnt_q - CW'(1);
                if (cnt_d == '0) state_d = FIX;
            end
            FIX: begin
                t_d = fix_res;
                state_d = DONE;
            end
            default: if (io.out_ready) state_d = IDLE;
        endcase
    end
    assign io.in_ready = state_q == IDLE;
    assign io.out_valid = state_q == DONE;
    assign io.busy = state_q != IDLE;
    assign io.t = t_q;
endmodule
